// File: rtl/dm_cache_if.sv
// ---------------------------------------------------------------
// dm_cache_if : strobe/rnotw/mfc request bus shared by CPU and slowmem sides
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface dm_cache_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
);
  logic              strobe;
  logic              rnotw;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              mfc;

  modport master (output strobe, rnotw, addr, wdata, input rdata, mfc);
  modport slave  (input strobe, rnotw, addr, wdata, output rdata, mfc);
endinterface

`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
// ---------------------------------------------------------------
// dm_cache_ctrl : direct-mapped, write-back, write-allocate cache controller
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module dm_cache_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  dm_cache_if.slave         cpu,
  dm_cache_if.master        mem,
  input  logic              flush,
  output logic              flush_done,
  output logic              cpu_busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int               LINES    = 1 << IDX_W;
  localparam int               TAG_W    = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_REFILL_REQ, S_REFILL_WAIT, S_FL_SCAN, S_FL_WR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rnotw;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [LINES-1:0]  r_valid, r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [WIDTH-1:0]  r_data [LINES];
  logic [IDX_W-1:0]  r_scan, w_scan_nxt;

  logic              r_cpu_mfc, r_busy, r_flush_done, r_mem_strobe, r_mem_rnotw;
  logic [WIDTH-1:0]  r_cpu_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic              w_latch, w_cpu_mfc, w_flush_done, w_mem_strobe, w_mem_rnotw;
  logic [WIDTH-1:0]  w_cpu_rdata, w_mem_wdata, w_line_data;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_line_we, w_line_dirty, w_hit_inc, w_miss_inc;
  logic [IDX_W-1:0]  w_line_idx;
  logic [TAG_W-1:0]  w_line_tag;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit, w_victim_dirty;

  assign w_idx          = r_addr[IDX_W-1:0];
  assign w_tag          = r_addr[ADDR_W-1:IDX_W];
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_scan_nxt   = r_scan;
    w_latch      = 1'b0;
    w_cpu_mfc    = 1'b0;
    w_cpu_rdata  = r_cpu_rdata;
    w_flush_done = 1'b0;
    w_mem_strobe = 1'b0;
    w_mem_rnotw  = 1'b1;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_line_we    = 1'b0;
    w_line_idx   = w_idx;
    w_line_dirty = 1'b0;
    w_line_tag   = w_tag;
    w_line_data  = r_wdata;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu.strobe) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOOKUP;
        end else if (flush) begin
          w_scan_nxt  = '0;
          w_state_nxt = S_FL_SCAN;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_hit_inc   = 1'b1;
          w_cpu_mfc   = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_rnotw) begin
            w_cpu_rdata = r_data[w_idx];
          end else begin
            w_line_we    = 1'b1;
            w_line_dirty = 1'b1;
          end
        end else begin
          w_miss_inc = 1'b1;
          if (w_victim_dirty) begin
            w_state_nxt = S_WB;
          end else if (r_rnotw) begin
            w_state_nxt = S_REFILL_REQ;
          end else begin
            w_line_we    = 1'b1;
            w_line_dirty = 1'b1;
            w_cpu_mfc    = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      S_WB: begin
        w_mem_strobe = 1'b1;
        w_mem_rnotw  = 1'b0;
        w_mem_addr   = {r_tag[w_idx], w_idx};
        w_mem_wdata  = r_data[w_idx];
        if (r_rnotw) begin
          w_state_nxt = S_REFILL_REQ;
        end else begin
          w_line_we    = 1'b1;
          w_line_dirty = 1'b1;
          w_cpu_mfc    = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_REFILL_REQ: begin
        // Hold one cycle after a writeback so strobes never abut.
        if (!r_mem_strobe) begin
          w_mem_strobe = 1'b1;
          w_mem_addr   = r_addr;
          w_state_nxt  = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (mem.mfc) begin
          w_line_we   = 1'b1;
          w_line_data = mem.rdata;
          w_cpu_rdata = mem.rdata;
          w_cpu_mfc   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FL_SCAN: begin
        if (r_valid[r_scan] && r_dirty[r_scan]) begin
          w_state_nxt = S_FL_WR;
        end else if (r_scan == LAST_IDX) begin
          w_flush_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_scan_nxt = r_scan + 1'b1;
        end
      end
      S_FL_WR: begin
        w_mem_strobe = 1'b1;
        w_mem_rnotw  = 1'b0;
        w_mem_addr   = {r_tag[r_scan], r_scan};
        w_mem_wdata  = r_data[r_scan];
        w_line_we    = 1'b1;
        w_line_idx   = r_scan;
        w_line_tag   = r_tag[r_scan];
        w_line_data  = r_data[r_scan];
        if (r_scan == LAST_IDX) begin
          w_flush_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_scan_nxt  = r_scan + 1'b1;
          w_state_nxt = S_FL_SCAN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rnotw      <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_scan       <= '0;
      r_cpu_mfc    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_busy       <= 1'b0;
      r_flush_done <= 1'b0;
      r_mem_strobe <= 1'b0;
      r_mem_rnotw  <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_latch) begin
        r_rnotw <= cpu.rnotw;
        r_addr  <= cpu.addr;
        r_wdata <= cpu.wdata;
      end
      if (w_line_we) begin
        r_valid[w_line_idx] <= 1'b1;
        r_dirty[w_line_idx] <= w_line_dirty;
        r_tag[w_line_idx]   <= w_line_tag;
        r_data[w_line_idx]  <= w_line_data;
      end
      r_scan       <= w_scan_nxt;
      r_cpu_mfc    <= w_cpu_mfc;
      r_cpu_rdata  <= w_cpu_rdata;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_flush_done <= w_flush_done;
      r_mem_strobe <= w_mem_strobe;
      r_mem_rnotw  <= w_mem_rnotw;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      if (w_hit_inc && (r_hit_cnt != {CNT_W{1'b1}}))   r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign cpu.rdata  = r_cpu_rdata;
  assign cpu.mfc    = r_cpu_mfc;
  assign mem.strobe = r_mem_strobe;
  assign mem.rnotw  = r_mem_rnotw;
  assign mem.addr   = r_mem_addr;
  assign mem.wdata  = r_mem_wdata;
  assign flush_done = r_flush_done;
  assign cpu_busy   = r_busy;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

`default_nettype wire
